// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    // True when exactly one active-low column line is asserted.
    function automatic logic one_low(input logic [NUM_COLS-1:0] col);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {2'b00, ~col[i]};
        end
        return (n == 3'd1);
    endfunction

    // Position of the low bit; only meaningful when one_low() holds.
    function automatic logic [1:0] low_pos(input logic [NUM_COLS-1:0] col);
        logic [1:0] p;
        p = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!col[i]) p = 2'(i);
        end
        return p;
    endfunction

    function automatic logic [3:0] key_index(input logic [1:0] row_idx,
                                             input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser for asynchronous active-low inputs; resets to idle (all ones).
module key_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, one-hot key output and valid/held flags.
// Optional build macro KEYPAD_CLEAR_ON_RELEASE_EN clears onehot on an accepted release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [NUM_ROWS-1:0]             row,
    input  logic [NUM_COLS-1:0]             col,
    output logic [NUM_ROWS*NUM_COLS-1:0]    onehot,
    output logic                            key_valid,
    output logic                            key_held
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [NUM_COLS-1:0] col_s;

    key_sync2 #(.WIDTH(NUM_COLS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col),
        .q     (col_s)
    );

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    state_t                          state, state_nxt;
    logic [NUM_ROWS-1:0]             row_q, row_nxt;
    logic [1:0]                      row_idx, row_idx_nxt;
    logic [NUM_COLS-1:0]             cap_pat, cap_pat_nxt;
    logic [1:0]                      cap_col, cap_col_nxt;
    logic [CW-1:0]                   deb_cnt, cnt_nxt;
    logic [NUM_ROWS*NUM_COLS-1:0]    onehot_q, onehot_nxt;
    logic                            valid_q, valid_nxt;
    logic                            held_q, held_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            row_q    <= 4'b1110;
            row_idx  <= '0;
            cap_pat  <= '1;
            cap_col  <= '0;
            deb_cnt  <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            row_q    <= row_nxt;
            row_idx  <= row_idx_nxt;
            cap_pat  <= cap_pat_nxt;
            cap_col  <= cap_col_nxt;
            deb_cnt  <= cnt_nxt;
            onehot_q <= onehot_nxt;
            valid_q  <= valid_nxt;
            held_q   <= held_nxt;
        end
    end

    // col_s seen at a tick belongs to the row driven since the previous tick.
    always_comb begin
        logic [CW-1:0] cnt_inc;
        state_nxt   = state;
        row_nxt     = row_q;
        row_idx_nxt = row_idx;
        cap_pat_nxt = cap_pat;
        cap_col_nxt = cap_col;
        cnt_nxt     = deb_cnt;
        onehot_nxt  = onehot_q;
        valid_nxt   = 1'b0;
        held_nxt    = held_q;
        cnt_inc     = deb_cnt + 1'b1;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low(col_s)) begin
                        cap_pat_nxt = col_s;
                        cap_col_nxt = low_pos(col_s);
                        cnt_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_nxt     = {row_q[NUM_ROWS-2:0], row_q[NUM_ROWS-1]};
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == cap_pat) begin
                        if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                            onehot_nxt = (NUM_ROWS*NUM_COLS)'(1) << key_index(row_idx, cap_col);
                            valid_nxt  = 1'b1;
                            held_nxt   = 1'b1;
                            cnt_nxt    = '0;
                            state_nxt  = PRESSED;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = SCAN;
                    end
                end
                PRESSED: begin
                    // Only an all-high pattern counts toward release; extra keys do not.
                    if (col_s == '1) begin
                        if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
                            held_nxt  = 1'b0;
                            cnt_nxt   = '0;
                            state_nxt = SCAN;
`ifdef KEYPAD_CLEAR_ON_RELEASE_EN
                            onehot_nxt = '0;
`endif
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    assign row       = row_q;
    assign onehot    = onehot_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: simulated key matrix, behavioural model, directed + random stimulus.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;

    localparam int M_SCAN  = 0;
    localparam int M_CHECK = 1;
    localparam int M_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low when its row is driven low.
    function automatic logic [3:0] col_of(input logic [3:0] r, input logic [15:0] k);
        logic [3:0] c;
        c = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (!r[ri] && k[ri*4+ci]) c[ci] = 1'b0;
        return c;
    endfunction

    always_comb col = col_of(row, keys);

    function automatic logic [3:0] row_of(input int i);
        logic [3:0] r;
        r = 4'hF;
        r[i] = 1'b0;
        return r;
    endfunction

    typedef struct {
        int          mode;
        int          row_i;
        logic [3:0]  cand_pat;
        int          cand_key;
        int          cnt;
        logic [15:0] onehot;
        bit          kv;
        bit          held;
        int          cyc;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.mode = M_SCAN; m.row_i = 0; m.cand_pat = 4'hF; m.cand_key = 0;
        m.cnt = 0; m.onehot = 16'h0; m.kv = 0; m.held = 0; m.cyc = 0;
        return m;
    endfunction

    // One clock of the scanner described by its rules: act on every CLK_DIV-th clock.
    function automatic model_t model_step(input model_t m, input logic [15:0] k);
        model_t n;
        logic [3:0] pat;
        int c;
        n = m;
        n.kv = 0;
        n.cyc = m.cyc + 1;
        if (m.cyc % CLK_DIV == CLK_DIV - 1) begin
            pat = col_of(row_of(m.row_i), k);
            if (m.mode == M_SCAN) begin
                if ($countones(~pat) == 1) begin
                    c = 0;
                    for (int i = 0; i < 4; i++) if (!pat[i]) c = i;
                    n.cand_pat = pat;
                    n.cand_key = m.row_i * 4 + c;
                    n.cnt = 0;
                    n.mode = M_CHECK;
                end else begin
                    n.row_i = (m.row_i + 1) % 4;
                end
            end else if (m.mode == M_CHECK) begin
                if (pat == m.cand_pat) begin
                    n.cnt = m.cnt + 1;
                    if (n.cnt == DEB) begin
                        n.onehot = 16'h0;
                        n.onehot[m.cand_key] = 1'b1;
                        n.kv = 1; n.held = 1; n.cnt = 0; n.mode = M_HOLD;
                    end
                end else begin
                    n.cnt = 0; n.mode = M_SCAN;
                end
            end else begin
                if (pat == 4'hF) begin
                    n.cnt = m.cnt + 1;
                    if (n.cnt == DEB) begin
                        n.held = 0; n.cnt = 0; n.mode = M_SCAN;
`ifdef KEYPAD_CLEAR_ON_RELEASE_EN
                        n.onehot = 16'h0;
`endif
                    end
                end else begin
                    n.cnt = 0;
                end
            end
        end
        return n;
    endfunction

    model_t mdl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= model_reset();
        else        mdl <= model_step(mdl, keys);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        check("row",       {28'd0, row},          {28'd0, row_of(mdl.row_i)});
        check("onehot",    {16'd0, onehot},       {16'd0, mdl.onehot});
        check("key_valid", {31'd0, key_valid},    {31'd0, mdl.kv});
        check("key_held",  {31'd0, key_held},     {31'd0, mdl.held});
        if (key_valid === 1'b1) pulses++;
    end

    task automatic ticks(input int n);
        repeat (n * CLK_DIV) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row"},    {28'd0, row},       32'h0000000E);
        check({tag, "_onehot"}, {16'd0, onehot},    32'h0);
        check({tag, "_valid"},  {31'd0, key_valid}, 32'h0);
        check({tag, "_held"},   {31'd0, key_held},  32'h0);
    endtask

    // Assert reset two clocks into a tick period, then release and realign to tick boundaries.
    task automatic pulse_reset(input string tag);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        ticks(1);
    endtask

    initial begin
        int p0;
        logic [3:0] rprev;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        ticks(1);

        check("rot1", {28'd0, row}, 32'hD);
        ticks(1); check("rot2", {28'd0, row}, 32'hB);
        ticks(1); check("rot3", {28'd0, row}, 32'h7);
        ticks(1); check("rot4", {28'd0, row}, 32'hE);

        pulse_reset("rst_mid");

        // Bounce on key 0: never stable for long enough.
        p0 = pulses;
        keys = 16'h0001; ticks(1);
        keys = 16'h0000; ticks(1);
        keys = 16'h0001; ticks(1);
        keys = 16'h0000; ticks(6);
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_onehot", {16'd0, onehot}, 32'h0);

        // Ghost: two columns low on row 0.
        p0 = pulses;
        keys = 16'h0003;
        ticks(8);
        rprev = row;
        ticks(1);
        check("ghost_rotates", {28'd0, row}, {28'd0, rprev[2:0], rprev[3]});
        check("ghost_pulses", pulses - p0, 0);
        keys = 16'h0000; ticks(2);

        // Stable press row2/col1.
        p0 = pulses;
        keys = 16'h0200;
        ticks(10);
        check("press_pulses", pulses - p0, 1);
        check("press_onehot", {16'd0, onehot}, 32'h0200);
        check("press_held", {31'd0, key_held}, 32'h1);
        check("press_row", {28'd0, row}, 32'hB);

        keys = 16'h0000;
        ticks(4);
        check("rel_held", {31'd0, key_held}, 32'h0);
`ifdef KEYPAD_CLEAR_ON_RELEASE_EN
        check("rel_onehot", {16'd0, onehot}, 32'h0);
`else
        check("rel_onehot", {16'd0, onehot}, 32'h0200);
`endif

        // Reset while the key is held, then re-debounce the same key.
        keys = 16'h0200;
        ticks(10);
        pulse_reset("rst_pressed");
        p0 = pulses;
        ticks(12);
        check("redeb_pulses", pulses - p0, 1);
        check("redeb_onehot", {16'd0, onehot}, 32'h0200);
        keys = 16'h0000;
        ticks(5);

        for (int s = 0; s < 200; s++) begin
            int kind;
            logic [15:0] k;
            kind = $urandom_range(0, 3);
            k = 16'h0;
            if (kind == 1 || kind == 2) k[$urandom_range(0, 15)] = 1'b1;
            else if (kind == 3) begin
                k[$urandom_range(0, 15)] = 1'b1;
                k[$urandom_range(0, 15)] = 1'b1;
            end
            keys = k;
            ticks($urandom_range(1, 8));
        end
        keys = 16'h0000;
        ticks(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 membrane keypad matrix: drives one row low at a time and reads the four active-low column lines.
- Synchronises and debounces the column lines.
- Publishes the pressed key as a registered 16-bit one-hot word, plus a one-cycle key_valid strobe.
- Sits directly upstream of the one-hot-to-digit encoder, which consumes onehot on the same clk.

Parameters:
- CLK_DIV, 1000, clk cycles per scan tick; legal range >= 4.
- DEBOUNCE_TICKS, 10, consecutive stable scan ticks required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row  output  4  row drive, active-low, exactly one bit low at all times
- col  input  4  column sense, active-low, externally pulled up, asynchronous
- onehot  output  16  registered key code, bit index = row_idx*4 + col_idx
- key_valid  output  1  one-clk pulse when onehot is updated by an accepted press
- key_held  output  1  high while the accepted key remains pressed

Behaviour:
- Reset (async assert, sync release): row=4'b1110, onehot=16'h0000, key_valid=0, key_held=0, state=SCAN, prescaler=0, debounce counter=0, synchroniser flops=4'b1111.
- col passes through a 2-flop synchroniser (col_s) before any use.
- Prescaler counts 0..CLK_DIV-1, then wraps. tick=1 for one clk when count==CLK_DIV-1. All FSM decisions occur only on tick clocks.
- Row settling: col_s is sampled at tick for the row driven since the previous tick; row advances in the same clk. CLK_DIV>=4 guarantees settle plus synchroniser delay.
- "valid column": col_s has exactly one bit low. Zero low bits, or two or more low bits (ghosting/multi-press), both count as no press.
- SCAN:
  - On tick with a valid column: capture row_idx/col_idx, freeze row, clear the counter, go to DEBOUNCE.
  - On tick otherwise: rotate row low bit 0->1->2->3->0.
- DEBOUNCE, on each tick:
  - If col_s equals the captured pattern: counter+1.
  - Else: go to SCAN, counter=0; row resumes rotation from the frozen row on the next tick.
  - When counter reaches DEBOUNCE_TICKS: onehot <= 1<<(row_idx*4+col_idx), key_valid=1 for that clk only, key_held=1, counter=0, go to PRESSED.
- PRESSED: row stays frozen.
  - On tick with col_s==4'b1111: counter+1.
  - On tick with any bit low: counter=0.
  - When counter reaches DEBOUNCE_TICKS: key_held=0, counter=0, go to SCAN.
  - onehot holds its value after release; the downstream encoder keeps its last digit.
- A second key pressed in the frozen row while in PRESSED makes the column pattern non-valid. It is neither a release nor a new key. The release count runs only on all-high.
- Press and release within one debounce window: no key_valid, onehot unchanged.
- rst_n asserted mid-debounce or mid-press: immediate return to reset values; no key_valid on release of reset.
- Latency: stable press to key_valid is at most 4 ticks (scan) + DEBOUNCE_TICKS ticks + 1 clk.

Optional Feature:
- Macro KEYPAD_CLEAR_ON_RELEASE_EN.
- Defined: on the accepted release (PRESSED->SCAN), onehot <= 16'h0000 in the same clk that key_held falls.
- Undefined: onehot retains the last accepted key until the next accepted press.
- key_valid behaviour is identical in both builds.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4
  - state enum {SCAN, DEBOUNCE, PRESSED}
  - function one_low(col) -> bit, implementing the exactly-one-low test
  - function key_index(row_idx,col_idx) -> 4-bit
- Sub-module key_sync2: parameterised-width 2-flop synchroniser, reset to all-ones.
- Prescaler and FSM stay inline.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3):
- Reset: assert rst_n=0 mid-count -> row=4'b1110, onehot=16'h0000, key_valid=0, key_held=0 immediately. Release with col=4'b1111 -> row cycles 1110,1101,1011,0111 every 4 clks.
- Stable press row2/col1 (col=4'b1101 only while row=4'b1011) -> onehot=16'h0200, a single key_valid pulse, key_held=1, row frozen at 4'b1011.
- Bounce: col toggles low/high each tick for 2 ticks, then releases -> no key_valid, onehot stays 16'h0000, scan resumes.
- Release after 16'h0200 press: col all-high for 3 ticks -> key_held=0, onehot stays 16'h0200. With KEYPAD_CLEAR_ON_RELEASE_EN -> onehot=16'h0000.
- Ghost: col=4'b1100 on row0 -> treated as no press, row keeps rotating, no key_valid.
- Reset mid-PRESSED with key still down: rst_n pulse -> reset values. After release of reset, the key re-debounces -> exactly one new key_valid with the same onehot.
